// File: rtl/ky32_mem_pkg.sv
// Shared types and constants for the KY32 unified-memory arbiter.
package ky32_mem_pkg;
  localparam int         KY32_XLEN   = 32;
  localparam logic [3:0] KY32_BE_ALL = 4'hF;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  typedef enum logic       {OWN_I, OWN_D}      owner_e;
endpackage

// File: rtl/ky32_mem_wdog.sv
// Saturating no-ack watchdog: expired fires on the TIMEOUT-th counted cycle.
module ky32_mem_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                                 cnt_d = '0;
    else if (count_en && cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Combinational so the abort lands on the same edge the last no-ack cycle ends.
  assign expired = count_en && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/ky32_mem_arb.sv
// Single-port memory arbiter: data-priority with fetch anti-starvation streak
// limit and a no-ack watchdog. All outputs are registered.
module ky32_mem_arb
  import ky32_mem_pkg::*;
#(
  parameter int STREAK  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [KY32_XLEN-1:0] i_addr,
  output logic                 i_ack,
  output logic [KY32_XLEN-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [KY32_XLEN-1:0] d_addr,
  input  logic [KY32_XLEN-1:0] d_wdata,
  input  logic [3:0]           d_be,
  output logic                 d_ack,
  output logic [KY32_XLEN-1:0] d_rdata,
  output logic                 err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [KY32_XLEN-1:0] mem_addr,
  output logic [KY32_XLEN-1:0] mem_wdata,
  output logic [3:0]           mem_be,
  input  logic                 mem_ack,
  input  logic [KY32_XLEN-1:0] mem_rdata
);
  localparam int SW = (STREAK > 0) ? $clog2(STREAK + 1) : 1;

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  logic [SW-1:0]        streak_q, streak_d;
  logic                 mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [KY32_XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]           mem_be_q, mem_be_d;
  logic                 i_ack_q, i_ack_d, d_ack_q, d_ack_d, err_q, err_d;
  logic [KY32_XLEN-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                 grant, pick_i, wd_exp;

  assign grant  = i_req | d_req;
  assign pick_i = i_req && (!d_req || streak_q == SW'(STREAK));

  ky32_mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q != ISSUE),
    .count_en ((state_q == ISSUE) && !mem_ack),
    .expired  (wd_exp)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant)             state_d = ISSUE;
      ISSUE:   if (mem_ack || wd_exp) state_d = RESP;
      RESP:                           state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      IDLE: if (grant) begin
        mem_req_d = 1'b1;
        if (pick_i) begin
          owner_d     = OWN_I;
          streak_d    = '0;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_be_d    = KY32_BE_ALL;
        end else begin
          owner_d     = OWN_D;
          // Streak only grows while fetch is actually being held off.
          if (i_req) streak_d = (streak_q == SW'(STREAK)) ? streak_q : streak_q + 1'b1;
          else       streak_d = '0;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
        end
      end
      ISSUE: if (mem_ack || wd_exp) begin
        mem_req_d = 1'b0;
        err_d     = !mem_ack;
        if (owner_q == OWN_I) begin
          i_ack_d   = 1'b1;
          i_rdata_d = mem_ack ? mem_rdata : '0;
        end else begin
          d_ack_d   = 1'b1;
          d_rdata_d = mem_ack ? mem_rdata : '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q     <= OWN_I;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_ky32_mem_arb.sv
// Directed bench for ky32_mem_arb (STREAK=4, TIMEOUT=8).
module tb_ky32_mem_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        i_ack, d_ack, err, mem_req, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ky32_mem_arb #(.STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got hang exp finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int hi_cnt;
    logic [1:0] exp_own [6];
    exp_own = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

    rst = 1'b0; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; d_be = '0;
    step(); step();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_acks", {29'd0, i_ack, d_ack, err}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    rst = 1'b1;
    step();

    // Fetch only, zero-wait memory
    i_req = 1; i_addr = 32'h100;
    step();
    chk("f_mem_req", {31'd0, mem_req}, 32'd1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_be", {28'd0, mem_be}, 32'hF);
    chk("f_mem_we", {31'd0, mem_we}, 32'd0);
    mem_ack = 1; mem_rdata = 32'h00500093;
    step();
    chk("f_i_ack", {31'd0, i_ack}, 32'd1);
    chk("f_i_rdata", i_rdata, 32'h00500093);
    chk("f_err", {31'd0, err}, 32'd0);
    chk("f_mem_req_drop", {31'd0, mem_req}, 32'd0);
    mem_ack = 0; i_req = 0;
    step();
    chk("f_ack_pulse", {31'd0, i_ack}, 32'd0);
    chk("f_rdata_hold", i_rdata, 32'h00500093);
    // Stray ack in IDLE must be ignored
    mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
    step();
    mem_ack = 0;
    chk("stray_ack", {30'd0, i_ack, d_ack}, 32'd0);
    chk("stray_rdata", i_rdata, 32'h00500093);

    // Simultaneous: data first, then fetch
    i_req = 1; i_addr = 32'h104;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
    step();
    chk("s_d_addr", mem_addr, 32'h2000);
    chk("s_d_be", {28'd0, mem_be}, 32'h3);
    chk("s_d_we", {31'd0, mem_we}, 32'd1);
    chk("s_d_wdata", mem_wdata, 32'hDEADBEEF);
    mem_ack = 1; mem_rdata = 32'h0;
    step();
    chk("s_d_ack", {30'd0, i_ack, d_ack}, 32'd1);
    mem_ack = 0; d_req = 0;
    step();
    step();
    chk("s_i_req", {31'd0, mem_req}, 32'd1);
    chk("s_i_addr", mem_addr, 32'h104);
    chk("s_i_be", {28'd0, mem_be}, 32'hF);
    chk("s_i_wdata", mem_wdata, 32'd0);
    chk("s_i_we", {31'd0, mem_we}, 32'd0);
    mem_ack = 1; mem_rdata = 32'h11111111;
    step();
    chk("s_i_ack", {30'd0, i_ack, d_ack}, 32'd2);
    chk("s_i_rdata", i_rdata, 32'h11111111);
    mem_ack = 0; i_req = 0;
    step();

    // Starvation guard: D,D,D,D,I,D
    i_req = 1; i_addr = 32'h200;
    d_req = 1; d_we = 0; d_addr = 32'h3000; d_be = 4'hF;
    for (int n = 0; n < 6; n++) begin
      step();
      chk($sformatf("stv_addr%0d", n), mem_addr, (exp_own[n] == 2'b10) ? 32'h200 : 32'h3000);
      mem_ack = 1; mem_rdata = 32'd100 + n;
      step();
      chk($sformatf("stv_ack%0d", n), {30'd0, i_ack, d_ack}, {30'd0, exp_own[n]});
      mem_ack = 0;
      step();
    end
    i_req = 0; d_req = 0;
    step();

    // Timeout: memory never acks
    d_req = 1; d_addr = 32'h4000;
    step();
    hi_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (!mem_req) break;
      hi_cnt++;
      step();
    end
    chk("to_req_cycles", hi_cnt, 32'd8);
    chk("to_d_ack", {31'd0, d_ack}, 32'd1);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_d_rdata", d_rdata, 32'd0);
    d_req = 0;
    step();
    chk("to_err_pulse", {31'd0, err}, 32'd0);

    // Ack on the expiry cycle counts as success
    d_req = 1; d_addr = 32'h5000;
    step();
    for (int c = 0; c < 7; c++) step();
    chk("to8_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    step();
    chk("to8_d_ack", {31'd0, d_ack}, 32'd1);
    chk("to8_err", {31'd0, err}, 32'd0);
    chk("to8_rdata", d_rdata, 32'hCAFEF00D);
    mem_ack = 0; d_req = 0;
    step();

    // Reset while a fetch is in flight
    i_req = 1; i_addr = 32'h300;
    step();
    chk("r_req", {31'd0, mem_req}, 32'd1);
    rst = 0; i_req = 0;
    step();
    chk("r_mem_req", {31'd0, mem_req}, 32'd0);
    chk("r_mem_addr", mem_addr, 32'd0);
    chk("r_rdata", i_rdata | d_rdata, 32'd0);
    rst = 1;
    step();
    chk("r_no_ack", {29'd0, i_ack, d_ack, mem_req}, 32'd0);
    i_req = 1; i_addr = 32'h300;
    step();
    chk("r2_req", {31'd0, mem_req}, 32'd1);
    chk("r2_addr", mem_addr, 32'h300);
    mem_ack = 1; mem_rdata = 32'h12345678;
    step();
    chk("r2_ack", {31'd0, i_ack}, 32'd1);
    chk("r2_rdata", i_rdata, 32'h12345678);
    mem_ack = 0; i_req = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
